// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
package riscv_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush. The head entry is read straight from
// registered storage, so there is no path from the write port to o_data.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_count
);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot the push lands in.
  assign w_push = i_push && ((r_count != FULL_C) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, response buffering, redirect/flush.
// Optional macro FETCH_MISALIGN_CHK_EN halts fetch on a misaligned redirect target.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        o_fetch_misalign
`endif
);
  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   MAX_C    = CW'(MAX_OUTSTANDING);
  localparam logic [1:0]      ST_IDLE  = IDLE;
  localparam logic [1:0]      ST_FETCH = FETCH;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [1:0]      ST_HALT  = HALT;
`endif

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [7:0]    r_discard;
  logic [31:0]   w_redir_pc;
  logic [CW-1:0] w_count;
  logic [63:0]   w_head;
  logic [CW:0]   w_credit;
  logic          w_req_valid;
  logic          w_acc;
  logic          w_rsp_keep;
  logic          w_pop;
  logic          w_nonempty;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;
  logic w_misalign;
  assign w_misalign       = (i_redirect_pc[1:0] != 2'b00);
  assign w_redir_pc       = i_redirect_pc;
  assign o_fetch_misalign = r_misalign;
`else
  assign w_redir_pc = i_redirect_pc & 32'hFFFF_FFFC;
`endif

  assign w_nonempty = (w_count != '0);
  assign w_pop      = w_nonempty && i_instr_ready && !i_redirect_valid;
  // Slots already promised to in-flight requests count against the buffer.
  assign w_credit   = {1'b0, r_outstanding} + {1'b0, w_count} - {{CW{1'b0}}, w_pop};
  assign w_req_valid = (r_state == ST_FETCH) && (w_credit < DEPTH_C) && (r_outstanding < MAX_C);
  assign w_acc      = w_req_valid && i_imem_req_ready;
  assign w_rsp_keep = i_imem_rsp_valid && (r_discard == 8'd0) && !i_redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= 8'd0;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE) r_state <= ST_FETCH;
      if (i_redirect_valid) begin
        r_pc          <= w_redir_pc;
        r_rsp_pc      <= w_redir_pc;
        r_outstanding <= '0;
        // Everything still in flight, including a word returning right now, is dropped.
        r_discard     <= r_discard + 8'(r_outstanding) + 8'(w_acc) - 8'(i_imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHK_EN
        r_state       <= w_misalign ? ST_HALT : ST_FETCH;
        r_misalign    <= w_misalign;
`endif
      end else begin
        if (w_acc) r_pc <= r_pc + 32'd4;
        r_outstanding <= r_outstanding + CW'(w_acc) - CW'(w_rsp_keep);
        if (i_imem_rsp_valid && (r_discard != 8'd0)) r_discard <= r_discard - 8'd1;
        if (w_rsp_keep) r_rsp_pc <= r_rsp_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .WIDTH(64),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_flush(i_redirect_valid),
    .i_push (w_rsp_keep),
    .i_data ({r_rsp_pc, i_imem_rsp_data}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(w_count)
  );

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_instr_valid    = w_nonempty;
  assign o_instr          = w_nonempty ? w_head[31:0]  : NOP_INSTR;
  assign o_instr_pc       = w_nonempty ? w_head[63:32] : 32'h0000_0000;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: epoch-tagged memory model plus an expected-PC stream model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam int          MAXO  = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .o_imem_req_valid(imem_req_valid),
    .i_imem_req_ready(imem_req_ready),
    .o_imem_req_addr (imem_req_addr),
    .i_imem_rsp_valid(imem_rsp_valid),
    .i_imem_rsp_data (imem_rsp_data),
    .o_instr_valid   (instr_valid),
    .i_instr_ready   (instr_ready),
    .o_instr         (instr),
    .o_instr_pc      (instr_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .o_fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] got_q[$];
  int          n_cmp = 0, n_fail = 0;
  int          cyc, epoch, m_occ, m_out, last_due, n_acc, n_drop;
  int          lat_min, lat_max, first_valid_cyc;
  logic [31:0] first_valid_pc, m_req_pc, m_exp_pc;
  bit          m_halt, m_mis, iready_en, rnd_ready, rnd_iready;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    got_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_got(input string name);
    int k;
    k = 0;
    while (got_q.size() == 0 && k < 40) begin
      tick(1);
      k++;
    end
    chk(name, 32'(got_q.size() != 0), 32'd1);
  endtask

  // Memory model, input driver and per-cycle comparison against the stream model.
  always @(negedge clk) begin
    int   oc, lat, due;
    bit   rsp_now, m_pop, exp_req, acc;
    logic [31:0] tgt;
    req_t e;
    if (!rst_n) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = 1'b1;
      instr_ready    = iready_en;
      mem_q.delete();
      cyc = 0; epoch = 0; m_occ = 0; m_out = 0; last_due = -1;
      m_req_pc = 32'h0; m_exp_pc = 32'h0; m_halt = 0; m_mis = 0;
      first_valid_cyc = -1; first_valid_pc = 32'hFFFF_FFFF;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    end else begin
      imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      instr_ready    = iready_en && (rnd_iready ? 1'($urandom_range(0, 1)) : 1'b1);
      rsp_now        = (mem_q.size() > 0) && (mem_q[0].due == cyc);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? memf(mem_q[0].addr) : 32'h0;
      #1;
      oc = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch == epoch) oc++;
      m_pop   = (m_occ != 0) && instr_ready && !redirect_valid;
      exp_req = (cyc >= 1) && !m_halt && (oc < MAXO) && (oc + m_occ - int'(m_pop) < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, m_req_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_occ != 0));
      if (m_occ != 0) begin
        chk("instr_pc", instr_pc, m_exp_pc);
        chk("instr", instr, memf(m_exp_pc));
      end
`ifdef FETCH_MISALIGN_CHK_EN
      chk("misalign", 32'(fetch_misalign), 32'(m_mis));
`endif
      if (instr_valid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        first_valid_pc  = instr_pc;
      end
      if (instr_valid && instr_ready && !redirect_valid) got_q.push_back(instr_pc);
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: imem_req_addr, epoch: epoch, due: due});
        m_req_pc += 32'd4;
        n_acc++;
      end
      if (rsp_now) begin
        e = mem_q.pop_front();
        if (e.epoch == epoch && !redirect_valid) m_occ++;
        else n_drop++;
      end
      if (m_pop) begin
        m_occ--;
        m_exp_pc += 32'd4;
      end
      if (redirect_valid) begin
        tgt = redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
        m_mis  = (tgt[1:0] != 2'b00);
        m_halt = m_mis;
`else
        tgt[1:0] = 2'b00;
`endif
        epoch++;
        m_occ    = 0;
        m_req_pc = tgt;
        m_exp_pc = tgt;
      end
      m_out = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch == epoch) m_out++;
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  ok;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    iready_en = 1; rnd_ready = 0; rnd_iready = 0; lat_min = 1; lat_max = 1;
    n_acc = 0; n_drop = 0;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    got_q.delete(); n_acc = 0;

    // 1: latency 1, always ready
    tick(10);
    chk("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
    chk("t1_first_valid_pc", first_valid_pc, 32'h0);
    chk("t1_delivered", 32'(got_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) chk("t1_pc_seq", got_q[i], 32'(i * 4));

    // 2: decode stalled after a mid-operation reset
    rst_n = 1'b0; iready_en = 0;
    tick(2);
    rst_n = 1'b1;
    got_q.delete(); n_acc = 0;
    tick(10);
    chk("t2_issued", 32'(n_acc), 32'd2);
    chk("t2_held", 32'(got_q.size()), 32'd0);
    iready_en = 1;
    tick(8);
    chk("t2_pc0", got_q[0], 32'h0);
    chk("t2_pc1", got_q[1], 32'h4);
    chk("t2_pc2", got_q[2], 32'h8);

    // 3: redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    ok = 0;
    for (k = 0; k < 50 && !ok; k++) begin
      if (m_out == 2) ok = 1;
      else tick(1);
    end
    chk("t3_two_outstanding", 32'(ok), 32'd1);
    n_drop = 0;
    do_redirect(32'h100);
    wait_got("t3_wait");
    chk("t3_first_pc", got_q[0], 32'h100);
    chk("t3_dropped", 32'(n_drop), 32'd2);

    // 4: redirect on a response cycle with decode ready
    lat_min = 1; lat_max = 1;
    tick(10);
    ok = 0;
    for (k = 0; k < 50 && !ok; k++) begin
      if (m_out == 1 && m_occ == 1 && mem_q.size() > 0 && mem_q[0].due == cyc) ok = 1;
      else tick(1);
    end
    chk("t4_setup", 32'(ok), 32'd1);
    n_drop = 0;
    do_redirect(32'h100);
    chk("t4_no_valid_after", 32'(instr_valid), 32'd0);
    wait_got("t4_wait");
    chk("t4_first_pc", got_q[0], 32'h100);
    chk("t4_dropped", 32'(n_drop), 32'd1);

    // PC wrap at the top of the address space
    do_redirect(32'hFFFF_FFF0);
    tick(10);
    chk("wrap_0", got_q[0], 32'hFFFF_FFF0);
    chk("wrap_3", got_q[3], 32'hFFFF_FFFC);
    chk("wrap_4", got_q[4], 32'h0000_0000);
    chk("wrap_5", got_q[5], 32'h0000_0004);

    // 5: random request backpressure, decode stalls and latency 1..3
    lat_min = 1; lat_max = 3; rnd_ready = 1; rnd_iready = 1;
    do_redirect(32'h1000);
    tick(400);
    rnd_ready = 0; rnd_iready = 0;
    chk("t5_progress", 32'(got_q.size() >= 20), 32'd1);
    for (int i = 0; i < got_q.size(); i++) chk("t5_pc_seq", got_q[i], 32'h1000 + 32'(i * 4));
    lat_min = 1; lat_max = 1;
    tick(5);

`ifdef FETCH_MISALIGN_CHK_EN
    // 6: misaligned redirect halts until an aligned one arrives
    do_redirect(32'h102);
    chk("t6_misalign_set", 32'(fetch_misalign), 32'd1);
    chk("t6_no_req", 32'(imem_req_valid), 32'd0);
    tick(6);
    chk("t6_still_halted", 32'(imem_req_valid), 32'd0);
    do_redirect(32'h200);
    chk("t6_misalign_clr", 32'(fetch_misalign), 32'd0);
    wait_got("t6_wait");
    chk("t6_first_pc", got_q[0], 32'h200);
`else
    // Low target bits are ignored without the alignment check
    do_redirect(32'h306);
    wait_got("align_wait");
    chk("align_first_pc", got_q[0], 32'h304);
`endif
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
